// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC sequencing, one-cycle-latency memory reads, and a small
// prefetch queue handed to decode over a valid/ready handshake.
module instruction_fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INST_WIDTH  = 16,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [INST_WIDTH-1:0] mem_inst,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INST_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  halted
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   pc;
  logic                    inflight;
  logic [ADDR_WIDTH-1:0]   inflight_pc;
  logic [INST_WIDTH-1:0]   q_inst [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]   q_pc   [QUEUE_DEPTH];
  logic [PTR_W-1:0]        rd_ptr, wr_ptr;
  logic [CNT_W-1:0]        count;
  logic                    has_space;
  logic                    push, pop;

  // Credit check counts the outstanding read so its response always has a slot.
  assign has_space = (SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(QUEUE_DEPTH);

  assign mem_req   = !reset && (state == RUN) && !halt && !redirect && has_space;
  assign mem_addr  = pc;
  assign push      = inflight && !redirect;
  assign out_valid = (count != '0) && !redirect;
  assign pop       = out_valid && out_ready;
  assign out_inst  = q_inst[rd_ptr];
  assign out_pc    = q_pc[rd_ptr];
  assign halted    = (state == HALTED);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Next state: redirect always restarts fetching, halt only acts from RUN.
  always_comb begin
    state_nxt = state;
    if (redirect)                    state_nxt = RUN;
    else if (state == RUN && halt)   state_nxt = HALTED;
  end

  // PC and in-flight read tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_req;
      if (mem_req) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_WIDTH'(1);
      end
    end
  end

  // Prefetch queue; redirect flushes by clearing pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_inst[wr_ptr] <= mem_inst;
        q_pc[wr_ptr]   <= inflight_pc;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
